// File: rtl/jt12_mixacc_if.sv
// Operator-slot bus into the FM channel mixer and the stereo sample it publishes.
// master drives the slot stream and reads the mix; slave is the mixer side.
interface jt12_mixacc_if #(
  parameter int CHANNELS  = 6,
  parameter int OPW       = 9,
  parameter int ACC_WIDTH = 16
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                        clk_en;
  logic                        zero;
  logic [CHW-1:0]              ch;
  logic [1:0]                  op;
  logic signed [OPW-1:0]       op_result;
  logic [2:0]                  alg;
  logic [1:0]                  rl;
  logic                        ch_en;
  logic                        pcm_en;
  logic signed [OPW-1:0]       pcm;
  logic signed [ACC_WIDTH-1:0] left;
  logic signed [ACC_WIDTH-1:0] right;
  logic                        sample;
  logic                        clip;

  modport master (
    output clk_en, zero, ch, op, op_result, alg, rl, ch_en, pcm_en, pcm,
    input  left, right, sample, clip
  );

  modport slave (
    input  clk_en, zero, ch, op, op_result, alg, rl, ch_en, pcm_en, pcm,
    output left, right, sample, clip
  );
endinterface

// File: rtl/jt12_mixacc.sv
// Time-multiplexed FM channel mixer: sums carrier operators per channel,
// limits each channel, pans it into stereo frame accumulators and publishes
// one saturated, scaled left/right sample per frame.
// Optional build macro: JT12_MIXACC_LADDER_EN adds a +/-4 DAC ladder offset
// to both sides of every channel commit.
module jt12_mixacc #(
  parameter int CHANNELS  = 6,
  parameter int OPW       = 9,
  parameter int ACC_WIDTH = 16,
  parameter int SHIFT     = 4
) (
  input logic          clk,
  input logic          rst_n,
  jt12_mixacc_if.slave bus
);
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DEPTH = 1 << CHW;
  localparam int SW    = OPW + 2;
  localparam int AW    = OPW + CHW + 2;
  localparam int OW    = AW + SHIFT;
  localparam int XW    = ((OW > ACC_WIDTH) ? OW : ACC_WIDTH) + 1;

  localparam logic [CHW-1:0]     PCM_CH = CHW'(CHANNELS - 1);
  localparam logic signed [SW:0] VMAX   = (SW + 1)'((2 ** (OPW - 1)) - 1);
  localparam logic signed [SW:0] VMIN   = (SW + 1)'(-(2 ** (OPW - 1)));

  logic signed [SW-1:0]        chsum_q [DEPTH];
  logic signed [SW-1:0]        chsum_d [DEPTH];
  logic signed [AW-1:0]        accl_q, accl_d, accr_q, accr_d;
  logic signed [OPW-1:0]       pcm_q, pcm_d;
  logic signed [ACC_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                        sample_q, sample_d, clip_q, clip_d;

  logic [3:0]            carriers;
  logic                  is_pcm;
  logic                  commit;
  logic signed [OPW-1:0] contrib;
  logic signed [OPW-1:0] v;
  logic signed [SW:0]    csum;
  logic signed [AW-1:0]  v_ext, add_l, add_r;
  logic [ACC_WIDTH:0]    scl_l, scl_r;
`ifdef JT12_MIXACC_LADDER_EN
  localparam logic signed [AW-1:0] DAC = AW'(4);
  logic signed [AW-1:0]  dac;
`endif

  // Scale a frame sum by SHIFT and saturate; MSB of the result flags clipping.
  function automatic logic [ACC_WIDTH:0] scale(input logic signed [AW-1:0] a);
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    x  = {{(XW - AW){a[AW-1]}}, a};
    x  = x <<< SHIFT;
    hi = '0;
    hi[ACC_WIDTH-2:0] = '1;
    lo = ~hi;
    if (x > hi)      scale = {1'b1, hi[ACC_WIDTH-1:0]};
    else if (x < lo) scale = {1'b1, lo[ACC_WIDTH-1:0]};
    else             scale = {1'b0, x[ACC_WIDTH-1:0]};
  endfunction

  assign scl_l = scale(accl_q);
  assign scl_r = scale(accr_q);

  // Carrier operator mask for the algorithm of the current channel (bit = op slot)
  always_comb begin
    carriers = 4'b1111;
    case (bus.alg)
      3'd0, 3'd1, 3'd2, 3'd3: carriers = 4'b1000;
      3'd4:                   carriers = 4'b1010;
      3'd5, 3'd6:             carriers = 4'b1110;
      default:                carriers = 4'b1111;
    endcase
  end

  // Slot contribution, limited channel value and the panned amounts committed at S4
  always_comb begin
    is_pcm  = bus.pcm_en && (bus.ch == PCM_CH);
    commit  = (bus.op == 2'd3);
    // A zero slot feeds its fresh PCM sample straight through to a same-slot commit.
    pcm_d   = (bus.clk_en && bus.zero) ? bus.pcm : pcm_q;
    contrib = (carriers[bus.op] && bus.ch_en && !is_pcm) ? bus.op_result : '0;
    csum    = {chsum_q[bus.ch][SW-1], chsum_q[bus.ch]} + {{3{contrib[OPW-1]}}, contrib};
    if (csum > VMAX)      v = {1'b0, {(OPW - 1){1'b1}}};
    else if (csum < VMIN) v = {1'b1, {(OPW - 1){1'b0}}};
    else                  v = csum[OPW-1:0];
    if (is_pcm) v = bus.ch_en ? pcm_d : '0;
    v_ext = {{(AW - OPW){v[OPW-1]}}, v};
`ifdef JT12_MIXACC_LADDER_EN
    dac   = v[OPW-1] ? -DAC : DAC;
    add_l = bus.rl[1] ? v_ext + dac : dac;
    add_r = bus.rl[0] ? v_ext + dac : dac;
`else
    add_l = bus.rl[1] ? v_ext : '0;
    add_r = bus.rl[0] ? v_ext : '0;
`endif
    if (!commit) begin
      add_l = '0;
      add_r = '0;
    end
  end

  // Next state: channel sums, frame accumulators, frame-end output publish
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) chsum_d[i] = chsum_q[i];
    accl_d   = accl_q;
    accr_d   = accr_q;
    left_d   = left_q;
    right_d  = right_q;
    clip_d   = clip_q;
    sample_d = 1'b0;
    if (bus.clk_en) begin
      if (bus.zero) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CHW'(i) != bus.ch) chsum_d[i] = '0;
        end
        left_d   = scl_l[ACC_WIDTH-1:0];
        right_d  = scl_r[ACC_WIDTH-1:0];
        clip_d   = scl_l[ACC_WIDTH] | scl_r[ACC_WIDTH];
        sample_d = 1'b1;
        accl_d   = add_l;
        accr_d   = add_r;
      end else begin
        accl_d = accl_q + add_l;
        accr_d = accr_q + add_r;
      end
      chsum_d[bus.ch] = commit ? '0 : chsum_q[bus.ch] + {{2{contrib[OPW-1]}}, contrib};
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) chsum_q[i] <= '0;
      accl_q   <= '0;
      accr_q   <= '0;
      pcm_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) chsum_q[i] <= chsum_d[i];
      accl_q   <= accl_d;
      accr_q   <= accr_d;
      pcm_q    <= pcm_d;
      left_q   <= left_d;
      right_q  <= right_d;
      sample_q <= sample_d;
      clip_q   <= clip_d;
    end
  end

  assign bus.left   = left_q;
  assign bus.right  = right_q;
  assign bus.sample = sample_q;
  assign bus.clip   = clip_q;
endmodule
